// File: rtl/melody_sequencer_if.sv
// Song-sequencer control/ROM/tone bus: player controls in, ROM address out,
// ROM data in, tone-generator and display outputs out.
interface melody_sequencer_if #(
  parameter int unsigned ADDR_W = 6,
  parameter int unsigned INC_W  = 18
);
  logic              PLAY;
  logic              STOP;
  logic              TEMPO_SEL;
  logic [ADDR_W-1:0] ROM_ADDR;
  logic [7:0]        ROM_DATA;
  logic [INC_W-1:0]  NOTE_INC;
  logic              NOTE_ON;
  logic [7:0]        GPIO_LED;
  logic              BUSY;
  logic              DONE;

  modport master (
    input  PLAY, STOP, TEMPO_SEL, ROM_DATA,
    output ROM_ADDR, NOTE_INC, NOTE_ON, GPIO_LED, BUSY, DONE
  );

  modport slave (
    output PLAY, STOP, TEMPO_SEL, ROM_DATA,
    input  ROM_ADDR, NOTE_INC, NOTE_ON, GPIO_LED, BUSY, DONE
  );
endinterface

// File: rtl/melody_sequencer.sv
// Song sequencer: fetches note/beat entries from a synchronous ROM and times each
// note in beats, driving the phase-increment word, tone enable and one-hot LEDs.
module melody_sequencer #(
  parameter int unsigned ADDR_W    = 6,
  parameter int unsigned INC_W     = 18,
  parameter int unsigned BEAT_FAST = 3538944,
  parameter int unsigned BEAT_SLOW = 7077888,
  parameter int unsigned GAP_TICKS = 65536,
  parameter bit          LOOP      = 1'b1
) (
  input  logic                USER_CLK,
  input  logic                RESET,
  melody_sequencer_if.master  bus
);

  localparam int unsigned BEAT_MAX = (BEAT_FAST > BEAT_SLOW) ? BEAT_FAST : BEAT_SLOW;
  localparam int unsigned TICK_MAX = (GAP_TICKS > BEAT_MAX) ? GAP_TICKS : BEAT_MAX;
  localparam int unsigned CNT_W    = $clog2(TICK_MAX + 1);
  localparam int unsigned GAP_LOAD = (GAP_TICKS == 0) ? 0 : GAP_TICKS - 1;

  typedef enum logic [2:0] {S_IDLE, S_FETCH, S_DECODE, S_SOUND, S_GAP} state_t;

  state_t            r_state, w_state;
  logic              r_play_d;
  logic [ADDR_W-1:0] r_addr, w_addr;
  logic [INC_W-1:0]  r_inc, w_inc;
  logic              r_on, w_on;
  logic [7:0]        r_led, w_led;
  logic              r_done, w_done;
  logic [CNT_W-1:0]  r_tick, w_tick;
  logic [3:0]        r_beat, w_beat;

  logic              w_play_edge;
  logic [3:0]        w_code;
  logic [3:0]        w_beats;
  logic [INC_W-1:0]  w_tab_inc;
  logic [7:0]        w_tab_led;
  logic [CNT_W-1:0]  w_beat_load;

  assign w_play_edge = bus.PLAY & ~r_play_d;
  assign w_code      = bus.ROM_DATA[7:4];
  assign w_beats     = bus.ROM_DATA[3:0];
  assign w_beat_load = bus.TEMPO_SEL ? CNT_W'(BEAT_FAST - 1) : CNT_W'(BEAT_SLOW - 1);

  always_comb begin
    w_tab_inc = '0;
    w_tab_led = '0;
    case (w_code)
      4'd1: begin w_tab_inc = INC_W'(11237); w_tab_led = 8'h01; end
      4'd2: begin w_tab_inc = INC_W'(12613); w_tab_led = 8'h02; end
      4'd3: begin w_tab_inc = INC_W'(14157); w_tab_led = 8'h04; end
      4'd4: begin w_tab_inc = INC_W'(15891); w_tab_led = 8'h08; end
      4'd5: begin w_tab_inc = INC_W'(16836); w_tab_led = 8'h10; end
      4'd6: begin w_tab_inc = INC_W'(18898); w_tab_led = 8'h20; end
      4'd7: begin w_tab_inc = INC_W'(21212); w_tab_led = 8'h40; end
      4'd8: begin w_tab_inc = INC_W'(25225); w_tab_led = 8'h80; end
      default: ;
    endcase
  end

  always_comb begin
    w_state = r_state;
    w_addr  = r_addr;
    w_inc   = r_inc;
    w_on    = r_on;
    w_led   = r_led;
    w_done  = 1'b0;
    w_tick  = r_tick;
    w_beat  = r_beat;
    case (r_state)
      S_IDLE: begin
        if (w_play_edge) begin
          w_addr  = '0;
          w_state = S_FETCH;
        end
      end
      S_FETCH: w_state = S_DECODE;
      S_DECODE: begin
        if (w_code == 4'hF) begin
          if (LOOP) begin
            w_addr  = '0;
            w_state = S_FETCH;
          end else begin
            w_done  = 1'b1;
            w_state = S_IDLE;
          end
        end else begin
          w_inc   = w_tab_inc;
          w_led   = w_tab_led;
          w_on    = (w_tab_led != 8'h00);
          w_tick  = w_beat_load;
          w_beat  = (w_beats == 4'd0) ? 4'd0 : w_beats - 4'd1;
          w_state = S_SOUND;
        end
      end
      S_SOUND: begin
        if (r_tick == '0) begin
          if (r_beat == 4'd0) begin
            w_inc   = '0;
            w_on    = 1'b0;
            w_led   = '0;
            w_addr  = r_addr + 1'b1;
            w_tick  = CNT_W'(GAP_LOAD);
            w_state = (GAP_TICKS == 0) ? S_FETCH : S_GAP;
          end else begin
            // tempo is re-sampled here so a change takes effect from the next beat
            w_beat = r_beat - 4'd1;
            w_tick = w_beat_load;
          end
        end else begin
          w_tick = r_tick - 1'b1;
        end
      end
      S_GAP: begin
        if (r_tick == '0) w_state = S_FETCH;
        else              w_tick  = r_tick - 1'b1;
      end
      default: w_state = S_IDLE;
    endcase
    if (bus.STOP) begin
      w_state = S_IDLE;
      w_addr  = '0;
      w_inc   = '0;
      w_on    = 1'b0;
      w_led   = '0;
      w_done  = 1'b0;
      w_tick  = '0;
      w_beat  = '0;
    end
  end

  always_ff @(posedge USER_CLK) begin
    if (RESET) begin
      r_state  <= S_IDLE;
      r_play_d <= 1'b0;
      r_addr   <= '0;
      r_inc    <= '0;
      r_on     <= 1'b0;
      r_led    <= '0;
      r_done   <= 1'b0;
      r_tick   <= '0;
      r_beat   <= '0;
    end else begin
      r_state  <= w_state;
      r_play_d <= bus.PLAY;
      r_addr   <= w_addr;
      r_inc    <= w_inc;
      r_on     <= w_on;
      r_led    <= w_led;
      r_done   <= w_done;
      r_tick   <= w_tick;
      r_beat   <= w_beat;
    end
  end

  assign bus.ROM_ADDR = r_addr;
  assign bus.NOTE_INC = r_inc;
  assign bus.NOTE_ON  = r_on;
  assign bus.GPIO_LED = r_led;
  assign bus.BUSY     = (r_state != S_IDLE);
  assign bus.DONE     = r_done;

endmodule
